// File: rtl/systemizer_loader.sv
// Host-side loader for the systemizer core: streams a matrix in, pulses start,
// waits for done and streams the systemized matrix back out on success.
module systemizer_loader #(
    parameter int L       = 8,
    parameter int K       = 16,
    parameter int M       = 3,
    parameter int BLOCK   = 4,
    parameter int TIMEOUT = 4096,
    localparam int EW     = (M > 1) ? $clog2(M) : 1,
    localparam int WW     = BLOCK * EW,
    localparam int DEPTH  = L * K / BLOCK,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          res_valid,
    output logic          res_success,
    output logic          res_fail,
    output logic          res_timeout,
    output logic          bad_elem,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [WW-1:0] sys_data_in,
    output logic          sys_start,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [WW-1:0] sys_data_out
);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_READ, S_CAPT, S_HOLD} state_t;
    state_t state, state_nx;

    logic [AW-1:0]    wcount, rcount;
    logic [TW-1:0]    wait_cnt;
    logic [BLOCK-1:0] elem_bad;
    logic             word_bad, timed_out, done_ok;

    // Widen by one bit so M that is a power of two still compares correctly.
    for (genvar j = 0; j < BLOCK; j++) begin : gen_elem
        assign elem_bad[j] = {1'b0, in_data[j*EW +: EW]} >= (EW+1)'(M);
    end
    assign word_bad  = |elem_bad;
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));
    // Contradictory success+fail from the core is treated as a failure.
    assign done_ok   = sys_success && !sys_fail;

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_HOLD);
    assign out_last  = out_valid && (rcount == LAST);

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        sys_wr_en   = 1'b0;
        sys_wr_addr = '0;
        sys_data_in = '0;
        sys_start   = 1'b0;
        sys_rd_en   = 1'b0;
        sys_rd_addr = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sys_wr_en   = 1'b1;
                    sys_data_in = in_data;
                    state_nx    = (LAST == '0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sys_wr_en   = 1'b1;
                    sys_wr_addr = wcount;
                    sys_data_in = in_data;
                    if (wcount == LAST) state_nx = S_START;
                end
            end
            S_START: begin
                sys_start = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                if (sys_done)       state_nx = done_ok ? S_READ : S_IDLE;
                else if (timed_out) state_nx = S_IDLE;
            end
            S_READ: begin
                sys_rd_en   = 1'b1;
                sys_rd_addr = rcount;
                state_nx    = S_CAPT;
            end
            S_CAPT: state_nx = S_HOLD;
            S_HOLD: if (out_ready) state_nx = (rcount == LAST) ? S_IDLE : S_READ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wcount      <= '0;
            rcount      <= '0;
            wait_cnt    <= '0;
            out_data    <= '0;
            res_valid   <= 1'b0;
            res_success <= 1'b0;
            res_fail    <= 1'b0;
            res_timeout <= 1'b0;
            bad_elem    <= 1'b0;
        end else begin
            state     <= state_nx;
            res_valid <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    wcount      <= (LAST == '0) ? '0 : AW'(1);
                    res_success <= 1'b0;
                    res_fail    <= 1'b0;
                    res_timeout <= 1'b0;
                    bad_elem    <= word_bad;
                end
                S_LOAD: if (in_valid) begin
                    if (wcount != LAST) wcount <= wcount + AW'(1);
                    bad_elem <= bad_elem | word_bad;
                end
                S_START: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (sys_done) begin
                        if (done_ok) begin
                            res_success <= 1'b1;
                            rcount      <= '0;
                        end else begin
                            res_fail  <= 1'b1;
                            res_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                    end
                end
                S_CAPT: out_data <= sys_data_out;
                S_HOLD: if (out_ready) begin
                    if (rcount == LAST) res_valid <= 1'b1;
                    else                rcount    <= rcount + AW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_systemizer_loader.sv
// Bench for systemizer_loader: behavioural systemizer memory, write/read scoreboards,
// a table of bad-element load vectors and hand sequences for timeout and reset.
module tb_systemizer_loader;
    localparam int DEPTH = 32, WW = 8, AW = 5, TMO = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready, out_last, busy;
    logic [WW-1:0] in_data = '0, out_data, sys_data_in, sys_data_out;
    logic res_valid, res_success, res_fail, res_timeout, bad_elem;
    logic sys_wr_en, sys_start, sys_rd_en;
    logic sys_done = 1'b0, sys_fail = 1'b0, sys_success = 1'b0;
    logic [AW-1:0] sys_wr_addr, sys_rd_addr;

    always #5 clk = ~clk;

    systemizer_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .res_valid(res_valid), .res_success(res_success), .res_fail(res_fail),
        .res_timeout(res_timeout), .bad_elem(bad_elem), .sys_wr_en(sys_wr_en),
        .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in), .sys_start(sys_start),
        .sys_done(sys_done), .sys_fail(sys_fail), .sys_success(sys_success),
        .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out));

    int chk = 0, fails = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Systemizer stand-in: identity memory with one-cycle read latency.
    logic [WW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sys_wr_en) mem[sys_wr_addr] <= sys_data_in;
        if (sys_rd_en) sys_data_out <= mem[sys_rd_addr];
    end

    typedef struct { logic [AW-1:0] a; logic [WW-1:0] d; } wr_t;
    typedef struct { logic [WW-1:0] d; logic last; } rd_t;
    wr_t wq[$];
    rd_t rq[$];
    wr_t we;
    rd_t re;
    int n_wr, n_rd, n_start, n_resv;
    logic [WW-1:0] held;
    bit stalled = 0;

    always @(negedge clk) begin
        if (rst) stalled = 0;
        else begin
            if (sys_wr_en) begin
                n_wr++;
                if (wq.size() == 0) check("wr_unexpected", 32'(wq.size()), 32'd1);
                else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(sys_wr_addr), 32'(we.a));
                    check("wr_data", 32'(sys_data_in), 32'(we.d));
                end
            end
            if (sys_rd_en) n_rd++;
            if (sys_start) n_start++;
            if (res_valid) n_resv++;
            if (out_valid && stalled) check("out_stable", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                if (rq.size() == 0) check("rd_unexpected", 32'(rq.size()), 32'd1);
                else begin
                    re = rq.pop_front();
                    check("rd_data", 32'(out_data), 32'(re.d));
                    check("rd_last", 32'(out_last), 32'(re.last));
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    end

    int ready_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 1) == 1);
            default: out_ready = 1'b0;
        endcase
    end

    logic [WW-1:0] ld [DEPTH];

    function automatic bit is_bad(input logic [WW-1:0] w);
        for (int j = 0; j < 4; j++) if (w[2*j +: 2] >= 2'd3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input bit gaps, input bit exp_rd);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = ld[i];
            wq.push_back('{a: AW'(i), d: ld[i]});
            if (exp_rd) rq.push_back('{d: ld[i], last: (i == DEPTH-1)});
            @(posedge clk); #1;
            if (i == 0) begin
                check("bad_first_word", 32'(bad_elem), 32'(is_bad(ld[0])));
                check("res_cleared", 32'({res_success, res_fail, res_timeout}), 32'd0);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic respond(input int delay, input bit ok);
        int n = 0;
        while (!sys_start && n < 50) begin @(posedge clk); #1; n++; end
        check("start_seen", 32'(sys_start), 32'd1);
        @(posedge clk); #1;   // first WAIT cycle
        if (delay >= 0) begin
            repeat (delay) begin @(posedge clk); #1; end
            sys_done = 1'b1; sys_success = ok; sys_fail = !ok;
            @(posedge clk); #1;
            sys_done = 1'b0; sys_success = 1'b0; sys_fail = 1'b0;
        end
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        check("res_valid_seen", 32'(res_valid), 32'd1);
        check("busy_dropped", 32'(busy), 32'd0);
    endtask

    // delay < 0 means the core never answers.
    task automatic op(input bit gaps, input int delay, input bit ok, input bit exp_bad, output int cyc);
        n_wr = 0; n_rd = 0; n_start = 0; n_resv = 0;
        load(gaps, ok && delay >= 0);
        respond(delay, ok);
        wait_end(cyc);
        @(posedge clk); #1;
        check("n_writes", 32'(n_wr), 32'd32);
        check("n_starts", 32'(n_start), 32'd1);
        check("n_reads", 32'(n_rd), (ok && delay >= 0) ? 32'd32 : 32'd0);
        check("n_res_valid", 32'(n_resv), 32'd1);
        check("res_valid_pulse", 32'(res_valid), 32'd0);
        check("res_flags", 32'({res_success, res_fail, res_timeout}),
              32'({ok && delay >= 0, !ok && delay >= 0, delay < 0}));
        check("bad_elem", 32'(bad_elem), 32'(exp_bad));
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
    endtask

    typedef struct { logic [WW-1:0] w; bit bad; } vec_t;
    vec_t tbl [7];
    int cyc;
    bit b;

    initial begin
        tbl[0] = '{w: 8'h00, bad: 1'b0};
        tbl[1] = '{w: 8'hC0, bad: 1'b1};
        tbl[2] = '{w: 8'hAA, bad: 1'b0};
        tbl[3] = '{w: 8'h03, bad: 1'b1};
        tbl[4] = '{w: 8'h55, bad: 1'b0};
        tbl[5] = '{w: 8'h0C, bad: 1'b1};
        tbl[6] = '{w: 8'h30, bad: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outs", 32'({out_valid, out_last, res_valid, res_success, res_fail, res_timeout,
                               bad_elem, sys_wr_en, sys_start, sys_rd_en}), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1/T2/T3: counting pattern with success, fail and timeout
        for (int i = 0; i < DEPTH; i++) ld[i] = WW'(i);
        op(0, 10, 1, 1, cyc);
        op(0, 10, 0, 1, cyc);
        op(0, -1, 0, 1, cyc);
        check("timeout_cycles", 32'(cyc), 32'd16);

        // T4: out-of-field element in word 0, sticky flag cleared per load
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < DEPTH; i++) ld[i] = i[0] ? 8'h21 : 8'h12;
            ld[0] = tbl[t].w;
            op(0, 3, 0, tbl[t].bad, cyc);
        end

        // T5: random data, input gaps, output stalls
        b = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ld[i] = WW'($urandom);
            b |= is_bad(ld[i]);
        end
        ready_mode = 1;
        op(1, 5, 1, b, cyc);
        ready_mode = 0;

        // T6a: reset during LOAD
        n_resv = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = ld[i];
            wq.push_back('{a: AW'(i), d: ld[i]});
            @(posedge clk); #1;
        end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("rstload_outs", 32'({busy, sys_wr_en, out_valid, res_valid, res_success, bad_elem}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        check("rstload_no_res", 32'(n_resv), 32'd0);

        // T6b: reset while holding a readback word
        ready_mode = 2;
        @(posedge clk); #1;
        load(0, 1);
        respond(2, 1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("hold_reached", 32'(out_valid), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("hold_data", 32'(out_data), 32'(ld[0]));
        n_resv = 0;
        rst = 1'b1;
        #1;
        check("rsthold_outs", 32'({busy, out_valid, out_last, res_valid, res_success, sys_rd_en}), 32'd0);
        check("rsthold_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rq.delete();
        ready_mode = 0;
        check("rsthold_no_res", 32'(n_resv), 32'd0);

        // Full run after reset
        for (int i = 0; i < DEPTH; i++) ld[i] = WW'(8'hE0 - i);
        b = 0;
        for (int i = 0; i < DEPTH; i++) b |= is_bad(ld[i]);
        op(0, 10, 1, b, cyc);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end
endmodule
